// File: rtl/interrupt_sequencer_if.sv
// Bundle of SFR, core-timing and sequencing signals exchanged between the
// core (master) and the interrupt sequencer (slave).
interface interrupt_sequencer_if #(
  parameter int PC_WIDTH = 15
);
  logic [7:0]          intcon_q;
  logic [7:0]          pir1_q;
  logic [7:0]          pie1_q;
  logic [7:0]          pir2_q;
  logic [7:0]          pie2_q;
  logic                instr_boundary;
  logic                sleeping;
  logic                retfie_exec;
  logic [PC_WIDTH-1:0] pc_current;

  logic                irq_pending;
  logic                wake;
  logic                flush;
  logic                push_en;
  logic [PC_WIDTH-1:0] push_pc;
  logic                shadow_save;
  logic                shadow_restore;
  logic                gie_clr;
  logic                gie_set;
  logic                vector_load;
  logic [PC_WIDTH-1:0] vector_addr;
  logic                busy;

  modport master (
    output intcon_q, pir1_q, pie1_q, pir2_q, pie2_q,
    output instr_boundary, sleeping, retfie_exec, pc_current,
    input  irq_pending, wake, flush, push_en, push_pc,
    input  shadow_save, shadow_restore, gie_clr, gie_set,
    input  vector_load, vector_addr, busy
  );

  modport slave (
    input  intcon_q, pir1_q, pie1_q, pir2_q, pie2_q,
    input  instr_boundary, sleeping, retfie_exec, pc_current,
    output irq_pending, wake, flush, push_en, push_pc,
    output shadow_save, shadow_restore, gie_clr, gie_set,
    output vector_load, vector_addr, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// PIC16F interrupt entry/exit controller: merges INTCON/PIR/PIE into a pending
// condition, requests wake from SLEEP, and sequences entry and RETFIE exit.
module interrupt_sequencer #(
  parameter int                  PC_WIDTH    = 15,
  parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = 15'h0004
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_VECTOR,
    S_IN_ISR,
    S_RETURN
  } state_e;

  state_e              r_state;
  state_e              w_next_state;
  logic                r_pending;
  logic [PC_WIDTH-1:0] r_ret_pc;
  logic                w_raw;
  logic                w_take_irq;

  // Core sources need only their own enable; peripheral sources also need PEIE.
  assign w_raw = (|(bus.intcon_q[5:3] & bus.intcon_q[2:0])) |
                 (bus.intcon_q[6] & ((|(bus.pir1_q & bus.pie1_q)) |
                                     (|(bus.pir2_q & bus.pie2_q))));

  assign w_take_irq = bus.instr_boundary & r_pending & bus.intcon_q[7];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_ret_pc  <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_raw;
      if (r_state == S_IDLE && w_take_irq)
        r_ret_pc <= bus.pc_current;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_next_state       = r_state;
    bus.flush          = 1'b0;
    bus.push_en        = 1'b0;
    bus.shadow_save    = 1'b0;
    bus.shadow_restore = 1'b0;
    bus.gie_clr        = 1'b0;
    bus.gie_set        = 1'b0;
    bus.vector_load    = 1'b0;
    bus.busy           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_take_irq)
          w_next_state = S_ENTRY;
        else if (bus.retfie_exec)
          w_next_state = S_RETURN;
      end
      S_ENTRY: begin
        bus.flush       = 1'b1;
        bus.push_en     = 1'b1;
        bus.shadow_save = 1'b1;
        bus.gie_clr     = 1'b1;
        bus.busy        = 1'b1;
        w_next_state    = S_VECTOR;
      end
      S_VECTOR: begin
        bus.vector_load = 1'b1;
        bus.busy        = 1'b1;
        w_next_state    = S_IN_ISR;
      end
      S_IN_ISR: begin
        bus.busy = 1'b1;
        if (bus.retfie_exec)
          w_next_state = S_RETURN;
      end
      S_RETURN: begin
        bus.gie_set        = 1'b1;
        bus.shadow_restore = 1'b1;
        w_next_state       = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Wake ignores GIE so a disabled-interrupt core still leaves SLEEP.
  assign bus.irq_pending = r_pending;
  assign bus.wake        = r_pending & bus.sleeping;
  assign bus.push_pc     = r_ret_pc;
  assign bus.vector_addr = VECTOR_ADDR;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: a cycle model of the entry/exit
// sequence is compared every cycle, plus hand-computed literal checks.
module tb_interrupt_sequencer;
  localparam int PW = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  interrupt_sequencer_if #(.PC_WIDTH(PW)) bus ();

  interrupt_sequencer #(.PC_WIDTH(PW), .VECTOR_ADDR(15'h0004)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit spec_raw(input logic [7:0] ic, p1, e1, p2, e2);
    return (|(ic[5:3] & ic[2:0])) || (ic[6] && ((|(p1 & e1)) || (|(p2 & e2))));
  endfunction

  // Model: where the sequence is, counted from the accepted boundary.
  bit          m_valid = 1'b0;
  bit          m_pending;
  logic [PW-1:0] m_ret_pc;
  int          m_entry_age;   // 0 none, 1 first cycle after accept, 2 second
  bit          m_in_isr;
  bit          m_returning;

  always @(posedge clk) begin
    if (rst) begin
      m_valid     <= 1'b1;
      m_pending   <= 1'b0;
      m_ret_pc    <= '0;
      m_entry_age <= 0;
      m_in_isr    <= 1'b0;
      m_returning <= 1'b0;
    end else begin
      m_pending   <= spec_raw(bus.intcon_q, bus.pir1_q, bus.pie1_q, bus.pir2_q, bus.pie2_q);
      m_entry_age <= 0;
      m_returning <= 1'b0;
      if (m_entry_age == 0 && !m_in_isr && !m_returning) begin
        if (bus.instr_boundary && m_pending && bus.intcon_q[7]) begin
          m_entry_age <= 1;
          m_ret_pc    <= bus.pc_current;
        end else if (bus.retfie_exec) begin
          m_returning <= 1'b1;
        end
      end else if (m_entry_age == 1) begin
        m_entry_age <= 2;
      end else if (m_entry_age == 2) begin
        m_in_isr <= 1'b1;
      end else if (m_in_isr && bus.retfie_exec) begin
        m_in_isr    <= 1'b0;
        m_returning <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("irq_pending",    bus.irq_pending,    m_pending);
      check("wake",           bus.wake,           m_pending & bus.sleeping);
      check("flush",          bus.flush,          m_entry_age == 1);
      check("push_en",        bus.push_en,        m_entry_age == 1);
      check("shadow_save",    bus.shadow_save,    m_entry_age == 1);
      check("gie_clr",        bus.gie_clr,        m_entry_age == 1);
      check("push_pc",        bus.push_pc,        m_ret_pc);
      check("vector_load",    bus.vector_load,    m_entry_age == 2);
      check("busy",           bus.busy,           (m_entry_age != 0) || m_in_isr);
      check("gie_set",        bus.gie_set,        m_returning);
      check("shadow_restore", bus.shadow_restore, m_returning);
      check("vector_addr",    bus.vector_addr,    15'h0004);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while in ENTRY: walk through VECTOR and ISR, RETFIE, back to IDLE.
  task automatic run_to_idle();
    tick();
    tick();
    bus.retfie_exec = 1'b1;
    tick();
    bus.retfie_exec = 1'b0;
    tick();
  endtask

  initial begin
    bus.intcon_q       = '0;
    bus.pir1_q         = '0;
    bus.pie1_q         = '0;
    bus.pir2_q         = '0;
    bus.pie2_q         = '0;
    bus.instr_boundary = 1'b0;
    bus.sleeping       = 1'b0;
    bus.retfie_exec    = 1'b0;
    bus.pc_current     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pending", bus.irq_pending, 1'b0);
    check("rst_busy",    bus.busy,        1'b0);
    check("rst_vector",  bus.vector_addr, 15'h0004);

    // Basic entry from TMR0 with GIE set.
    bus.intcon_q   = 8'hA4;
    bus.pc_current = 15'h0123;
    check("t1_pend_lag", bus.irq_pending, 1'b0);
    tick();
    check("t1_pend", bus.irq_pending, 1'b1);
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    bus.pc_current     = 15'h0200;
    check("t1_flush",   bus.flush,   1'b1);
    check("t1_push",    bus.push_en, 1'b1);
    check("t1_push_pc", bus.push_pc, 15'h0123);
    check("t1_gie_clr", bus.gie_clr, 1'b1);
    tick();
    check("t1_vload", bus.vector_load, 1'b1);
    check("t1_busy",  bus.busy,        1'b1);
    tick();
    check("t1_isr_vload", bus.vector_load, 1'b0);
    // Boundary inside the ISR must not re-enter.
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("t1_isr_noflush", bus.flush, 1'b0);
    check("t1_isr_busy",    bus.busy,  1'b1);

    // RETFIE with flag still set, then re-entry at next boundary.
    bus.retfie_exec = 1'b1;
    tick();
    bus.retfie_exec = 1'b0;
    check("t4_gie_set", bus.gie_set,        1'b1);
    check("t4_restore", bus.shadow_restore, 1'b1);
    check("t4_busy",    bus.busy,           1'b0);
    tick();
    check("t4_idle_set", bus.gie_set, 1'b0);
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("t4_reentry",    bus.flush,   1'b1);
    check("t4_reentry_pc", bus.push_pc, 15'h0200);
    bus.intcon_q = 8'h00;
    run_to_idle();

    // Peripheral source gated by PEIE.
    bus.intcon_q = 8'h80;
    bus.pir1_q   = 8'h01;
    bus.pie1_q   = 8'h01;
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("t2_no_pend",  bus.irq_pending, 1'b0);
    check("t2_no_entry", bus.flush,       1'b0);
    bus.intcon_q = 8'hC0;
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("t2_entry", bus.flush, 1'b1);
    bus.pir1_q   = 8'h00;
    bus.intcon_q = 8'h00;
    run_to_idle();
    // PIR2/PIE2 pair through PEIE, no GIE.
    bus.intcon_q = 8'h40;
    bus.pir2_q   = 8'h10;
    bus.pie2_q   = 8'h10;
    tick();
    check("t2_pir2_pend", bus.irq_pending, 1'b1);
    bus.pie2_q = 8'h00;
    tick();
    check("t2_pir2_off", bus.irq_pending, 1'b0);
    bus.intcon_q = 8'h00;
    bus.pir2_q   = 8'h00;

    // Wake from SLEEP without GIE, then entry once GIE is raised.
    bus.sleeping = 1'b1;
    bus.intcon_q = 8'h12;
    check("t3_wake_lag", bus.wake, 1'b0);
    tick();
    check("t3_wake", bus.wake, 1'b1);
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("t3_no_entry", bus.flush, 1'b0);
    bus.intcon_q       = 8'h92;
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    check("t3_entry", bus.flush, 1'b1);
    bus.sleeping = 1'b0;
    bus.intcon_q = 8'h00;
    run_to_idle();

    // Reset in VECTOR suppresses the remaining sequence.
    bus.intcon_q = 8'hA4;
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    tick();
    check("t5_vector", bus.vector_load, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_vload", bus.vector_load, 1'b0);
    check("t5_busy",  bus.busy,        1'b0);
    check("t5_pend",  bus.irq_pending, 1'b0);
    check("t5_retpc", bus.push_pc,     15'h0000);

    // RETFIE during ENTRY ignored; RETFIE in IDLE gives one RETURN cycle.
    tick();
    bus.instr_boundary = 1'b1;
    tick();
    bus.instr_boundary = 1'b0;
    bus.retfie_exec    = 1'b1;
    tick();
    bus.retfie_exec = 1'b0;
    check("t6_vload",  bus.vector_load, 1'b1);
    check("t6_no_ret", bus.gie_set,     1'b0);
    tick();
    check("t6_isr", bus.busy, 1'b1);
    bus.intcon_q    = 8'h00;
    bus.retfie_exec = 1'b1;
    tick();
    bus.retfie_exec = 1'b0;
    tick();
    tick();
    bus.retfie_exec = 1'b1;
    tick();
    bus.retfie_exec = 1'b0;
    check("t6_idle_ret",     bus.gie_set,        1'b1);
    check("t6_idle_restore", bus.shadow_restore, 1'b1);
    check("t6_idle_busy",    bus.busy,           1'b0);
    tick();
    check("t6_ret_done", bus.gie_set, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
